// File: rtl/uart_rx.sv
// Oversampling UART receiver: start + 8 data bits (LSB first) + optional parity + stop.
// Bytes leave on a valid/ready port with per-byte parity/framing flags and an overrun pulse.
module uart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       oversample_tick,
  input  logic       rx,
  input  logic       parity_en,
  input  logic       parity_odd,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_BIT = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_BIT = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rxs;
  logic [TW-1:0]          tcnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shifter;
  logic                   par_en;
  logic                   par_odd;
  logic                   perr;
  logic                   bit_point;

  assign rxs       = sync[SYNC_STAGES-1];
  assign bit_point = (tcnt == FULL_BIT);
  assign busy      = (state != IDLE);

  // Synchroniser idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tcnt       <= '0;
      bit_idx    <= '0;
      shifter    <= '0;
      par_en     <= 1'b0;
      par_odd    <= 1'b0;
      perr       <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (oversample_tick) begin
        case (state)
          IDLE: begin
            if (!rxs) begin
              tcnt  <= '0;
              state <= START;
            end
          end
          START: begin
            if (tcnt == HALF_BIT) begin
              if (!rxs) begin
                tcnt    <= '0;
                bit_idx <= '0;
                par_en  <= parity_en;
                par_odd <= parity_odd;
                perr    <= 1'b0;
                state   <= DATA;
              end else begin
                state <= IDLE;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          DATA: begin
            if (bit_point) begin
              tcnt    <= '0;
              shifter <= {rxs, shifter[7:1]};
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == 3'd7) begin
                state <= par_en ? PARITY : STOP;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          PARITY: begin
            if (bit_point) begin
              tcnt  <= '0;
              perr  <= rxs ^ (^shifter) ^ par_odd;
              state <= STOP;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          STOP: begin
            if (bit_point) begin
              tcnt  <= '0;
              state <= rxs ? IDLE : WAIT_IDLE;
              // A held, unaccepted byte wins; the new one is dropped.
              if (out_valid && !out_ready) begin
                overrun <= 1'b1;
              end else begin
                out_valid  <= 1'b1;
                out_data   <= shifter;
                parity_err <= perr;
                frame_err  <= !rxs;
              end
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          WAIT_IDLE: begin
            if (rxs) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
